ixc_gfifo_arb: RTL
==================

Name: ixc_gfifo_arb

Overview:
- Round-robin arbiter and sequencer that shares one global-FIFO (GF) write slot among NPORT GFIFO ports.
- Each port presents a level request with a callback id, a length and a 512-bit payload word.
- The arbiter selects one port, registers its word, and drives the GF interface under GF-full backpressure.
- It returns a one-cycle grant pulse to the winner, bounds bursts per port, and honours the global lock.

Parameters:
NPORT, 4, number of requesting ports (2..8)
CBW, 20, callback-id width
LENW, 12, length field width
DW, 512, payload word width
MAXBURST, 8, max consecutive words granted to one port before rotation (1..255)

Ports:
fclk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  NPORT  per-port level request; held until that port's gnt pulse
cbid  in  NPORT*CBW  per-port callback id, port p at [p*CBW +: CBW]
len  in  NPORT*LENW  per-port length, same packing
idata  in  NPORT*DW  per-port payload word, same packing
lock  in  1  global lock (GFLock); blocks new grants
gf_full  in  1  GF cannot accept this cycle
gnt  out  NPORT  one-hot, one-cycle grant/consume pulse
gf_req  out  1  GF write strobe
gf_cbid  out  CBW  registered cbid of the word in flight
gf_len  out  LENW  registered len of the word in flight
gf_data  out  DW  registered payload of the word in flight
gnt_id  out  clog2(NPORT)  index of the current owner
busy  out  1  high in any state other than IDLE and LOCKED

Behaviour:
- Reset values: FSM=IDLE, rr_ptr=0, burst_cnt=0, gnt=0, gf_req=0, gf_cbid/gf_len/gf_data=0, gnt_id=0, busy=0.
- Reset is asynchronous; asserting it mid-transfer drops the word silently (no gnt, no gf_req).
- States:
  - IDLE:
    - lock=1 -> LOCKED.
    - Else, if any req: winner = first set req scanning rr_ptr, rr_ptr+1, ... mod NPORT.
    - Capture the winner's cbid/len/idata into gf_* regs, set gnt_id=winner, burst_cnt=1, -> SEND.
  - SEND:
    - gf_req = gnt[gnt_id] = !gf_full (combinational from state and gf_full; data is already registered).
    - gf_full=0 -> GAP.
    - gf_full=1 -> stay in SEND; outputs stable; no timeout.
  - GAP (one cycle, lets the port advance its local buffer):
    - If req[gnt_id]=1 and burst_cnt<MAXBURST and lock=0: recapture the same port, burst_cnt++, -> SEND.
    - Else rr_ptr = gnt_id+1 mod NPORT, burst_cnt=0, -> IDLE (LOCKED if lock=1).
  - LOCKED: gf_req=0, gnt=0; when lock=0 -> IDLE.
- Latency: req sampled in IDLE at cycle t -> gf_req at t+1 if gf_full=0. Sustained single-port throughput is 1 word per 2 cycles.
- Lock:
  - Sampled only in IDLE and GAP.
  - A word already in SEND completes, then the FSM enters LOCKED (or IDLE if lock has dropped).
- Simultaneous requests: strictly rotating priority. A port dropping req in IDLE before selection is never granted.
- Burst: after MAXBURST words, the owner must rotate even if other req are low. If only it is requesting, it wins again from IDLE (+1 cycle).
- rr_ptr wraps NPORT-1 -> 0.
- gnt is never asserted for more than one port, and never while gf_full=1.
- gf_* registers change only on capture.
- Assertion (verification): gf_req implies $onehot(gnt), and gnt[gnt_id]==gf_req.

Test Plan:
- Reset, then req[2]=1 with cbid=0x00ABC, len=0x040, idata=pattern A -> at t+1: gf_req=1, gnt=4'b0100, gf_cbid=0x00ABC, gf_len=0x040, gf_data=A; busy=1 until IDLE.
- req=4'b1011 held continuously, MAXBURST=1 -> grant order 0,1,3,0,1,3; exactly one gnt bit per gf_req pulse.
- gf_full=1 for 5 cycles while in SEND -> gf_req=0 and gnt=0 for those 5 cycles, gf_data stable; a single gnt pulse in the cycle gf_full falls.
- req[0] held high, MAXBURST=8, req[1]=1 -> 8 words to port 0 (gnt pulses 2 cycles apart), then port 1 granted next; rr_ptr=1 afterwards.
- lock rises during SEND with gf_full=0 -> the current word completes (one gnt), FSM enters LOCKED, no gf_req while lock=1; lock falls -> pending req granted within 2 cycles.
- rst pulsed while in SEND with gf_full=1 -> all outputs 0 immediately; after release with req still held, a fresh grant starts from rr_ptr=0.

Source files
------------

// File: rtl/ixc_gfifo_arb.sv
// Round-robin arbiter that shares one global-FIFO write slot among NPORT ports.
// Bounds per-port bursts, stalls on gf_full and respects the global lock.
module ixc_gfifo_arb #(
  parameter int unsigned NPORT    = 4,
  parameter int unsigned CBW      = 20,
  parameter int unsigned LENW     = 12,
  parameter int unsigned DW       = 512,
  parameter int unsigned MAXBURST = 8
) (
  input  logic                            fclk,
  input  logic                            rst,
  input  logic [NPORT-1:0]                req,
  input  logic [NPORT*CBW-1:0]            cbid,
  input  logic [NPORT*LENW-1:0]           len,
  input  logic [NPORT*DW-1:0]             idata,
  input  logic                            lock,
  input  logic                            gf_full,
  output logic [NPORT-1:0]                gnt,
  output logic                            gf_req,
  output logic [CBW-1:0]                  gf_cbid,
  output logic [LENW-1:0]                 gf_len,
  output logic [DW-1:0]                   gf_data,
  output logic [$clog2(NPORT)-1:0]        gnt_id,
  output logic                            busy
);

  localparam int unsigned IDW = $clog2(NPORT);
  localparam int unsigned BCW = 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CBW-1:0]  gf_cbid_q;
  logic [LENW-1:0] gf_len_q;
  logic [DW-1:0]   gf_data_q;
  logic            cap_en;
  logic [IDW-1:0]  cap_idx;
  logic            win_vld;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  next_ptr;
  int unsigned     scan_idx;

  // First requester at or after rr_ptr, wrapping modulo NPORT
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NPORT;
      if (!win_vld && req[IDW'(scan_idx)]) begin
        win_vld = 1'b1;
        win_idx = IDW'(scan_idx);
      end
    end
  end

  assign next_ptr = (gnt_id_q == IDW'(NPORT - 1)) ? '0 : gnt_id_q + IDW'(1);

  // Next-state and strobe logic; gf_req/gnt follow gf_full directly in SEND
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    burst_cnt_d = burst_cnt_q;
    cap_en      = 1'b0;
    cap_idx     = gnt_id_q;
    gf_req      = 1'b0;
    gnt         = '0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (lock) begin
          state_d = LOCKED;
        end else if (win_vld) begin
          cap_en      = 1'b1;
          cap_idx     = win_idx;
          gnt_id_d    = win_idx;
          burst_cnt_d = BCW'(1);
          state_d     = SEND;
        end
      end
      SEND: begin
        busy = 1'b1;
        if (!gf_full) begin
          gf_req        = 1'b1;
          gnt[gnt_id_q] = 1'b1;
          state_d       = GAP;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (req[gnt_id_q] && (burst_cnt_q < BCW'(MAXBURST)) && !lock) begin
          cap_en      = 1'b1;
          burst_cnt_d = burst_cnt_q + BCW'(1);
          state_d     = SEND;
        end else begin
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
          state_d     = lock ? LOCKED : IDLE;
        end
      end
      LOCKED: begin
        if (!lock) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // In-flight word registers only move on capture
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      gf_cbid_q <= '0;
      gf_len_q  <= '0;
      gf_data_q <= '0;
    end else if (cap_en) begin
      gf_cbid_q <= cbid[cap_idx*CBW +: CBW];
      gf_len_q  <= len[cap_idx*LENW +: LENW];
      gf_data_q <= idata[cap_idx*DW +: DW];
    end
  end

  assign gf_cbid = gf_cbid_q;
  assign gf_len  = gf_len_q;
  assign gf_data = gf_data_q;
  assign gnt_id  = gnt_id_q;

endmodule
